// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory access unit:
//     - RISC-V load/store funct3 size/sign encodings
//     - FSM state type and state constants (IDLE, ACCESS, RESP)
//     - helpers that decode funct3 into access size, signedness and legality
//   No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    // Access size as log2(bytes): 0=B, 1=H, 2=W, 3=D.
    // Codes that are illegal for the configured width fall back to a full-word
    // access, which is what the unit does when faults are not reported.
    function automatic logic [1:0] size_from_funct3(input logic [2:0] funct3,
                                                    input int unsigned data_w);
        logic [1:0] full_size;
        logic [1:0] size;
        full_size = (data_w == 64) ? 2'd3 : 2'd2;
        case (funct3)
            F3_B, F3_BU: size = 2'd0;
            F3_H, F3_HU: size = 2'd1;
            F3_W:        size = 2'd2;
            F3_WU:       size = (data_w == 64) ? 2'd2 : full_size;
            default:     size = full_size;
        endcase
        return size;
    endfunction

    function automatic logic funct3_is_unsigned(input logic [2:0] funct3);
        return funct3[2];
    endfunction

    function automatic logic funct3_is_legal(input logic [2:0] funct3,
                                             input int unsigned data_w);
        logic legal;
        case (funct3)
            F3_D, F3_WU: legal = (data_w == 64);
            3'b111:      legal = 1'b0;
            default:     legal = 1'b1;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// -----------------------------------------------------------------------------
// dmem_access_unit_if
//   Request/response bundle between a load/store pipeline stage (master) and
//   the data-memory access unit (slave).
//   Request : req_valid, req_ready, req_write, req_mem_to_reg, req_funct3,
//             req_addr, req_wdata
//   Response: resp_valid, resp_ready, resp_wd, resp_err
// -----------------------------------------------------------------------------
interface dmem_access_unit_if #(
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_mem_to_reg;
    logic [2:0]        req_funct3;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_wd;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_mem_to_reg, req_funct3, req_addr,
               req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_wd, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_mem_to_reg, req_funct3, req_addr,
               req_wdata, resp_ready,
        output req_ready, resp_valid, resp_wd, resp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
//   Purely combinational byte-lane logic for one DATA_W-bit memory word.
//   Ports:
//     rd_word     in   current contents of the addressed word
//     wdata       in   store data, LSB-aligned
//     offset      in   byte offset of the access inside the word (aligned)
//     size_log2   in   access size, log2 of byte count
//     is_unsigned in   1 = zero-extend loads, 0 = sign-extend
//     load_data   out  addressed bytes, extended to DATA_W
//     merged_word out  rd_word with the addressed bytes replaced by wdata
// -----------------------------------------------------------------------------
module dmem_lane_align #(
    parameter  int DATA_W = 64,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rd_word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [OFF_W-1:0]  offset,
    input  logic [1:0]        size_log2,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged_word
);
    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] wd_shifted;
    logic [BYTES-1:0]  byte_mask;

    // NOTE: every output of this block gets a value before any conditional
    // logic, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        load_data   = '0;
        merged_word = rd_word;

        rd_shifted = rd_word >> {offset, 3'b000};
        wd_shifted = wdata << {offset, 3'b000};
        byte_mask  = BYTES'((16'd1 << (16'd1 << size_log2)) - 16'd1) << offset;

        // Size casts of a signed operand sign-extend; of an unsigned one, zero-extend.
        case (size_log2)
            2'd0: load_data = is_unsigned ? DATA_W'(rd_shifted[7:0])
                                          : DATA_W'($signed(rd_shifted[7:0]));
            2'd1: load_data = is_unsigned ? DATA_W'(rd_shifted[15:0])
                                          : DATA_W'($signed(rd_shifted[15:0]));
            2'd2: load_data = is_unsigned ? DATA_W'(rd_shifted[31:0])
                                          : DATA_W'($signed(rd_shifted[31:0]));
            default: load_data = rd_shifted;
        endcase

        for (int i = 0; i < BYTES; i++) begin
            if (byte_mask[i]) begin
                merged_word[i*8 +: 8] = wd_shifted[i*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
//   Single-outstanding load/store unit in front of a DEPTH x DATA_W data array.
//   A request is captured in IDLE, the array is read (and, for stores,
//   read-modify-written) in ACCESS, and the response is presented in RESP
//   until the consumer takes it. resp_valid rises two clocks after accept.
//
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     bus    slave side of dmem_access_unit_if (request and response channels)
//
//   Build option DMEM_ERR_EN: report out-of-range, illegal funct3 and
//   misaligned accesses on resp_err; faulting stores are dropped and faulting
//   loads return zero. Without it resp_err is 0, misaligned addresses are
//   aligned down, and illegal codes act as a full-word access.
// -----------------------------------------------------------------------------
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_access_unit_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    state_t state;

    // Captured request
    logic              cap_write;
    logic              cap_mem_to_reg;
    logic [2:0]        cap_funct3;
    logic [DATA_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    // Result of the ACCESS cycle, presented one clock later
    logic [DATA_W-1:0] stage_wd;

    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_wd_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              in_range;
    logic [1:0]        size_log2;
    logic [OFF_W-1:0]  size_mask;
    logic [OFF_W-1:0]  offset;
    logic              fault;
    logic              mem_we;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] result_wd;

    always_comb begin
        word_idx  = cap_addr >> OFF_W;
        in_range  = word_idx < DATA_W'(DEPTH);
        mem_idx   = word_idx[IDX_W-1:0];
        size_log2 = size_from_funct3(cap_funct3, DATA_W);
        size_mask = OFF_W'((4'd1 << size_log2) - 4'd1);
        // Aligning down is harmless when faults are reported: a misaligned
        // access never touches the array in that build.
        offset    = cap_addr[OFF_W-1:0] & ~size_mask;
`ifdef DMEM_ERR_EN
        fault     = !in_range || !funct3_is_legal(cap_funct3, DATA_W) ||
                    (|(cap_addr[OFF_W-1:0] & size_mask));
`else
        fault     = 1'b0;
`endif
        rd_word   = in_range ? mem[mem_idx] : '0;
        mem_we    = (state == ST_ACCESS) && cap_write && in_range && !fault;

        if (!cap_write && fault) begin
            result_wd = '0;
        end else if (cap_mem_to_reg) begin
            result_wd = cap_write ? '0 : (in_range ? load_data : '0);
        end else begin
            result_wd = cap_addr;
        end
    end

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .rd_word     (rd_word),
        .wdata       (cap_wdata),
        .offset      (offset),
        .size_log2   (size_log2),
        .is_unsigned (funct3_is_unsigned(cap_funct3)),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // NOTE: the array has no reset; its write enable depends on the
    // asynchronously reset FSM, so a reset during ACCESS drops the store
    // before the commit edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= merged_word;
        end
    end

`ifdef DMEM_ERR_EN
    logic stage_err;
    logic resp_err_q;
`endif

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cap_write      <= 1'b0;
            cap_mem_to_reg <= 1'b0;
            cap_funct3     <= '0;
            cap_addr       <= '0;
            cap_wdata      <= '0;
            stage_wd       <= '0;
            resp_valid_q   <= 1'b0;
            resp_wd_q      <= '0;
`ifdef DMEM_ERR_EN
            stage_err      <= 1'b0;
            resp_err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        cap_write      <= bus.req_write;
                        cap_mem_to_reg <= bus.req_mem_to_reg;
                        cap_funct3     <= bus.req_funct3;
                        cap_addr       <= bus.req_addr;
                        cap_wdata      <= bus.req_wdata;
                        state          <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    stage_wd <= result_wd;
`ifdef DMEM_ERR_EN
                    stage_err <= fault;
`endif
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    // First RESP cycle loads the output registers; they then
                    // hold until the consumer accepts.
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                        resp_wd_q    <= stage_wd;
`ifdef DMEM_ERR_EN
                        resp_err_q   <= stage_err;
`endif
                    end else if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_wd    = resp_wd_q;
`ifdef DMEM_ERR_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_unit
//   Self-checking bench for dmem_access_unit (DATA_W=64, DEPTH=1024).
//   Table of load/store vectors with expected writeback/error, a scoreboard
//   queue filled at issue and drained at response, plus hand sequences for
//   response back-pressure and reset during ACCESS.
//   Expected values follow DMEM_ERR_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_dmem_access_unit;
    import dmem_pkg::*;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 1024;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_access_unit_if #(.DATA_W(DATA_W)) bus ();

    dmem_access_unit #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        write;
        logic        m2r;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_wd;
        logic        exp_err;
        string       name;
    } vec_t;

    typedef struct {
        logic [63:0] wd;
        logic        err;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic m2r, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] exp_wd, input logic exp_err,
                                input string name);
        vec_t v;
        v.write = w; v.m2r = m2r; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_wd = exp_wd; v.exp_err = exp_err; v.name = name;
        return v;
    endfunction

    // Issue one request, check the response via the scoreboard. stall > 0
    // holds resp_ready low for that many cycles after resp_valid rises.
    task automatic run_vec(input vec_t v, input int stall);
        exp_t e;
        int   cyc;
        @(negedge clk);
        check({v.name, " req_ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid      = 1'b1;
        bus.req_write      = v.write;
        bus.req_mem_to_reg = v.m2r;
        bus.req_funct3     = v.f3;
        bus.req_addr       = v.addr;
        bus.req_wdata      = v.wdata;
        bus.resp_ready     = (stall == 0);
        sb_q.push_back('{wd: v.exp_wd, err: v.exp_err, name: v.name});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        cyc = 0;
        while (!bus.resp_valid && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb_q.pop_front();
        check({e.name, " latency"}, 64'(cyc), 64'd2);
        if (!bus.resp_valid) begin
            bus.resp_ready = 1'b1;
            return;
        end
        check({e.name, " resp_wd"}, bus.resp_wd, e.wd);
        check({e.name, " resp_err"}, 64'(bus.resp_err), 64'(e.err));
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge clk); #1;
                check({e.name, " held valid"}, 64'(bus.resp_valid), 64'd1);
                check({e.name, " held wd"}, bus.resp_wd, e.wd);
                check({e.name, " req_ready low"}, 64'(bus.req_ready), 64'd0);
            end
            bus.resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        if (stall > 0) begin
            check({e.name, " valid after hs"}, 64'(bus.resp_valid), 64'd0);
            check({e.name, " idle after hs"}, 64'(bus.req_ready), 64'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n              = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_write      = 1'b0;
        bus.req_mem_to_reg = 1'b0;
        bus.req_funct3     = 3'b000;
        bus.req_addr       = '0;
        bus.req_wdata      = '0;
        bus.resp_ready     = 1'b1;

        vecs.push_back(mk(1, 0, F3_D,  64'h10,   64'hDEADBEEF_CAFEF00D, 64'h10, 0, "SD 0x10"));
        vecs.push_back(mk(0, 1, F3_D,  64'h10,   64'h0, 64'hDEADBEEF_CAFEF00D, 0, "LD 0x10"));
        vecs.push_back(mk(1, 0, F3_B,  64'h13,   64'h80, 64'h13, 0, "SB 0x13"));
        vecs.push_back(mk(0, 1, F3_B,  64'h13,   64'h0, 64'hFFFFFFFF_FFFFFF80, 0, "LB 0x13"));
        vecs.push_back(mk(0, 1, F3_BU, 64'h13,   64'h0, 64'h80, 0, "LBU 0x13"));
        vecs.push_back(mk(0, 1, F3_D,  64'h10,   64'h0, 64'hDEADBEEF_80FEF00D, 0, "LD merged"));
        vecs.push_back(mk(0, 0, F3_W,  64'h10,   64'h0, 64'h10, 0, "LW no m2r"));
        vecs.push_back(mk(0, 1, F3_W,  64'h14,   64'h0, 64'hFFFFFFFF_DEADBEEF, 0, "LW 0x14"));
        vecs.push_back(mk(0, 1, F3_WU, 64'h14,   64'h0, 64'h00000000_DEADBEEF, 0, "LWU 0x14"));
        vecs.push_back(mk(0, 1, F3_H,  64'h16,   64'h0, 64'hFFFFFFFF_FFFFDEAD, 0, "LH 0x16"));
        vecs.push_back(mk(0, 1, F3_HU, 64'h12,   64'h0, 64'h80FE, 0, "LHU 0x12"));
        vecs.push_back(mk(1, 1, F3_D,  64'h18,   64'h01234567_89ABCDEF, 64'h0, 0, "SD m2r"));
        vecs.push_back(mk(1, 0, F3_H,  64'h1A,   64'hFFFF1234, 64'h1A, 0, "SH 0x1A"));
        vecs.push_back(mk(0, 1, F3_D,  64'h18,   64'h0, 64'h01234567_1234CDEF, 0, "LD 0x18"));
        vecs.push_back(mk(1, 0, F3_D,  64'h0,    64'h11111111_11111111, 64'h0, 0, "SD 0x0"));
        vecs.push_back(mk(1, 0, F3_D,  64'h1FF8, 64'h55555555_55555555, 64'h1FF8, 0, "SD last"));
        vecs.push_back(mk(0, 1, F3_D,  64'h1FF8, 64'h0, 64'h55555555_55555555, 0, "LD last"));
        vecs.push_back(mk(1, 0, F3_D,  64'h2000, 64'hFFFFFFFF_FFFFFFFF, 64'h2000, ERR_EN, "SD oor"));
        vecs.push_back(mk(0, 1, F3_D,  64'h2000, 64'h0, 64'h0, ERR_EN, "LD oor"));
        vecs.push_back(mk(0, 1, F3_D,  64'h0,    64'h0, 64'h11111111_11111111, 0, "LD 0x0 nowrap"));
        vecs.push_back(mk(0, 1, F3_H,  64'h11,   64'h0,
                          ERR_EN ? 64'h0 : 64'hFFFFFFFF_FFFFF00D, ERR_EN, "LH misalign"));
        vecs.push_back(mk(0, 1, 3'b111, 64'h10,  64'h0,
                          ERR_EN ? 64'h0 : 64'hDEADBEEF_80FEF00D, ERR_EN, "L f3=111"));
        vecs.push_back(mk(0, 1, F3_W,  64'h16,   64'h0,
                          ERR_EN ? 64'h0 : 64'hFFFFFFFF_DEADBEEF, ERR_EN, "LW misalign"));
        vecs.push_back(mk(1, 0, F3_W,  64'h1E,   64'hAAAAAAAA, 64'h1E, ERR_EN, "SW misalign"));
        vecs.push_back(mk(0, 1, F3_D,  64'h18,   64'h0,
                          ERR_EN ? 64'h01234567_1234CDEF : 64'hAAAAAAAA_1234CDEF, 0,
                          "LD after SW"));

        repeat (3) @(posedge clk);
        #1;
        check("reset resp_valid", 64'(bus.resp_valid), 64'd0);
        check("reset resp_wd", bus.resp_wd, 64'd0);
        check("reset resp_err", 64'(bus.resp_err), 64'd0);
        check("reset req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], 0);
        end

        // Back-pressure: response held for 5 cycles with resp_ready low.
        run_vec(mk(0, 1, F3_D, 64'h10, 64'h0, 64'hDEADBEEF_80FEF00D, 0, "LD stall"), 5);

        // Reset during ACCESS must abort the store.
        run_vec(mk(1, 0, F3_D, 64'h20, 64'hA5A5A5A5_A5A5A5A5, 64'h20, 0, "SD 0x20"), 0);
        @(negedge clk);
        bus.req_valid      = 1'b1;
        bus.req_write      = 1'b1;
        bus.req_mem_to_reg = 1'b0;
        bus.req_funct3     = F3_D;
        bus.req_addr       = 64'h20;
        bus.req_wdata      = 64'h1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort resp_valid", 64'(bus.resp_valid), 64'd0);
        check("abort resp_wd", bus.resp_wd, 64'd0);
        check("abort resp_err", 64'(bus.resp_err), 64'd0);
        check("abort req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(0, 1, F3_D, 64'h20, 64'h0, 64'hA5A5A5A5_A5A5A5A5, 0, "LD after abort"), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
